// File: rtl/vend_pkg.sv
// Shared vending datapath definitions: coin encodings, limits,
// FSM state types and the coin value helper.
package vend_pkg;

    localparam logic [2:0] FIVE   = 3'b001;
    localparam logic [2:0] TEN    = 3'b010;
    localparam logic [2:0] TWENTY = 3'b100;

    localparam int MAX_MONEY = 60;

    typedef enum logic [2:0] {
        C_IDLE,
        C_COLLECT,
        C_VEND,
        C_RETURN_CHANGE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_CHECK,
        D_PICK,
        D_OFFER,
        D_FINISH
    } disp_state_t;

    function automatic logic [7:0] coin_value(input logic [2:0] c);
        logic [7:0] v;
        v = 8'd0;
        case (c)
            FIVE:    v = 8'd5;
            TEN:     v = 8'd10;
            TWENTY:  v = 8'd20;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: largest coin that fits the amount and is in stock.
// Priority is 20, then 10, then 5; none flags that nothing qualifies.
module coin_select
    import vend_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [7:0]       remaining,
    input  logic [CNT_W-1:0] stock_5,
    input  logic [CNT_W-1:0] stock_10,
    input  logic [CNT_W-1:0] stock_20,
    output logic [2:0]       coin,
    output logic             none
);

    logic fit_5;
    logic fit_10;
    logic fit_20;

    assign fit_20 = (remaining >= coin_value(TWENTY)) && (stock_20 != '0);
    assign fit_10 = (remaining >= coin_value(TEN))    && (stock_10 != '0);
    assign fit_5  = (remaining >= coin_value(FIVE))   && (stock_5  != '0);

    always_comb begin
        coin = 3'b000;
        none = 1'b0;
        if (fit_20) begin
            coin = TWENTY;
        end else if (fit_10) begin
            coin = TEN;
        end else if (fit_5) begin
            coin = FIVE;
        end else begin
            none = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Return-path change dispenser: pays a change amount one coin per ack,
// largest coin first, tracking per-denomination stock and shortfall.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int INIT_5     = 4,
    parameter int INIT_10    = 4,
    parameter int INIT_20    = 4,
    parameter int CNT_W      = 4,
    parameter int MAX_AMOUNT = MAX_MONEY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [7:0]       req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic [2:0]       coin,
    input  logic             coin_ack,
    input  logic             refill,
    output logic             done,
    output logic             short,
    output logic [7:0]       remaining,
    output logic [CNT_W-1:0] stock_5,
    output logic [CNT_W-1:0] stock_10,
    output logic [CNT_W-1:0] stock_20
);

    localparam logic [CNT_W-1:0] S5_INIT  = CNT_W'(INIT_5);
    localparam logic [CNT_W-1:0] S10_INIT = CNT_W'(INIT_10);
    localparam logic [CNT_W-1:0] S20_INIT = CNT_W'(INIT_20);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [7:0]       MAX_AMT  = 8'(MAX_AMOUNT);

    disp_state_t state_q;
    disp_state_t state_d;

    logic [2:0] coin_q;
    logic [2:0] sel_coin;
    logic       sel_none;
    logic       accept;
    logic       take;
    logic       bad_amount;

    assign req_ready  = (state_q == D_IDLE);
    assign coin_valid = (state_q == D_OFFER);
    assign done       = (state_q == D_FINISH);
    assign coin       = coin_valid ? coin_q : 3'b000;

    assign accept = req_valid && req_ready;
    assign take   = coin_valid && coin_ack;

    // CHECK sees the freshly latched request in remaining.
    assign bad_amount = (remaining > MAX_AMT) ||
                        ((remaining % 8'd5) != 8'd0);

    coin_select #(
        .CNT_W(CNT_W)
    ) u_coin_select (
        .remaining(remaining),
        .stock_5  (stock_5),
        .stock_10 (stock_10),
        .stock_20 (stock_20),
        .coin     (sel_coin),
        .none     (sel_none)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE: begin
                if (accept) state_d = D_CHECK;
            end
            D_CHECK: begin
                state_d = bad_amount ? D_FINISH : D_PICK;
            end
            D_PICK: begin
                if (remaining == 8'd0 || sel_none) begin
                    state_d = D_FINISH;
                end else begin
                    state_d = D_OFFER;
                end
            end
            D_OFFER: begin
                if (coin_ack) state_d = D_PICK;
            end
            D_FINISH: begin
                state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= 8'd0;
            short     <= 1'b0;
            coin_q    <= 3'b000;
            stock_5   <= S5_INIT;
            stock_10  <= S10_INIT;
            stock_20  <= S20_INIT;
        end else begin
            case (state_q)
                D_IDLE: begin
                    if (refill) begin
                        stock_5  <= S5_INIT;
                        stock_10 <= S10_INIT;
                        stock_20 <= S20_INIT;
                    end
                    if (accept) begin
                        remaining <= req_amount;
                        short     <= 1'b0;
                    end
                end
                D_CHECK: begin
                    if (bad_amount) short <= 1'b1;
                end
                D_PICK: begin
                    if (remaining != 8'd0) begin
                        if (sel_none) begin
                            short <= 1'b1;
                        end else begin
                            coin_q <= sel_coin;
                        end
                    end
                end
                D_OFFER: begin
                    if (take) begin
                        remaining <= remaining - coin_value(coin_q);
                        if (coin_q[0]) stock_5  <= stock_5  - ONE;
                        if (coin_q[1]) stock_10 <= stock_10 - ONE;
                        if (coin_q[2]) stock_20 <= stock_20 - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
